i2c_master_prog: RTL and testbench
==================================

Name: i2c_master_prog

Overview:
- I2C initiator that drives the on-chip `i2c_slave` programming port, or an external slave, with single-register write and read transactions.
- Sequence: START, 7-bit device address + R/W, register-address byte, then one data byte written, or a repeated START and one byte read.
- Intended use: a bench/board-side programmer that loads instruction memory over SDA/SCL and reads it back for verification.
- Open-drain style: the block only pulls lines low or releases them.

Parameters:
- QDIV, 4, system clocks per SCL quarter-period (must be ≥1); one SCL bit = 4*QDIV clocks.
- CW, 8, width of the quarter-period counter (must hold QDIV-1).

Ports:
- i_clk  in  1  system clock; all logic on rising edge
- i_rst  in  1  synchronous reset, active high
- i_start  in  1  request pulse/level; accepted only when o_busy=0
- i_rw  in  1  0=write, 1=read; latched at accept
- i_dev_addr  in  7  slave address; latched at accept
- i_reg_addr  in  8  register/instruction address byte; latched at accept
- i_wdata  in  8  write data; latched at accept
- o_rdata  out  8  read data; valid while o_done=1 after a read, and held until the next accept
- o_busy  out  1  transaction in progress
- o_done  out  1  one-cycle pulse at transaction end
- o_nack  out  1  set with o_done if any ACK slot sampled high; held until the next accept
- i_sda  in  1  sampled SDA line (resolved bus value)
- o_sda_oe  out  1  1=pull SDA low, 0=release
- o_scl_oe  out  1  1=pull SCL low, 0=release

Behaviour:
- Clock/reset: one clock (i_clk). Reset i_rst is synchronous and active-high.
- Reset values: o_busy=0, o_done=0, o_nack=0, o_rdata=0, o_sda_oe=0, o_scl_oe=0, state IDLE, counters 0.
- Reset mid-transaction: both lines are released on the next edge. No STOP is generated.
- Accept: in IDLE with i_start=1, latch all inputs, clear o_nack, reset the quarter counter. o_busy=1 from the next cycle.
- i_start while busy: ignored, no queuing.
- Quarter tick: counter counts 0..QDIV-1 and ticks when it equals QDIV-1. Each segment spans 4 ticks, phases p0..p3.
- START / repeated START segment: p0 release SDA (SCL held low if already low); p1 release SCL; p2 pull SDA low; p3 pull SCL low.
- Data bit segment: p0 set SDA (pull low for 0, release for 1) while SCL low; p1 release SCL; p2 sample i_sda into the shift register; p3 pull SCL low. Bits are sent MSB first.
- ACK slot (master receiving): SDA released at p0; i_sda sampled at p2; 1 = NACK.
- Master ACK after read byte: always NACK (SDA released).
- STOP segment: p0 pull SDA low; p1 release SCL; p2 release SDA; p3 idle hold.
- FSM: IDLE → START → ADDR(8 bits: dev_addr,0) → ACK1 → REG(8) → ACK2 → then:
  - write: WDATA(8) → ACK3 → STOP;
  - read: RSTART → RADDR(dev_addr,1) → ACK4 → RDATA(8) → MNACK → STOP.
  - STOP → DONE → IDLE.
- NACK on any ACK slot: set o_nack and go directly to STOP (remaining bytes skipped).
- DONE cycle: o_done=1 and o_busy=0 in the same cycle, one clock after STOP's final tick. o_rdata is updated from the shift register at that cycle for reads.
- Latency: accept at cycle A → o_done at cycle A+1+N*4*QDIV.
  - Write: N=29 segments.
  - Read: N=39 segments.
  - NACK at the address byte: N=11.
- SCL is never stretched; the block does not monitor SCL. Arbitration is not supported.

Decomposition:
- Shared package `i2c_pkg`: state enum (IDLE, START, ADDR, ACK1, REG, ACK2, WDATA, ACK3, RSTART, RADDR, ACK4, RDATA, MNACK, STOP, DONE), phase constants P0..P3, RW_WRITE=0 / RW_READ=1.
- Sub-module `i2c_qtick_gen`: QDIV quarter-period divider with synchronous clear on accept, output one-cycle tick.
- FSM, bit counter (0..7), shift register and line drivers stay in `i2c_master_prog`.

Test Plan:
- Write with ACKing slave model, QDIV=2, dev=0x2A, reg=0x10, wdata=0xA5 → bus shows START, 0x54, ACK, 0x10, ACK, 0xA5, ACK, STOP; o_done at A+233; o_nack=0.
- Read, slave returns 0x3C, QDIV=2, dev=0x2A, reg=0x04 → bytes 0x54, 0x04, repeated START, 0x55; master NACKs after data; o_rdata=0x3C with o_done at A+313.
- No slave (i_sda tied 1), write → o_nack=1 with o_done at A+1+11*8=A+89; STOP seen; lines released.
- i_start held high during a transaction → exactly one transaction; a second one starts the cycle after o_done only if i_start is still high.
- i_rst asserted during the REG byte → next cycle o_sda_oe=0, o_scl_oe=0, o_busy=0; no o_done pulse.
- QDIV=1 write → timing scales to A+117; START/STOP SDA edges occur only while SCL is high.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM states, bit phases and R/W codes for the I2C register programmer
package i2c_pkg;
  typedef enum logic [3:0] {
    IDLE, START, ADDR, ACK1, REG, ACK2, WDATA, ACK3,
    RSTART, RADDR, ACK4, RDATA, MNACK, STOP, DONE
  } state_e;
  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd3;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ = 1'b1;
  function automatic logic is_tx(state_e s);
    return s inside {ADDR, REG, WDATA, RADDR};
  endfunction
  function automatic logic is_ack(state_e s);
    return s inside {ACK1, ACK2, ACK3, ACK4};
  endfunction
endpackage

// File: rtl/i2c_qtick_gen.sv
// i2c_qtick_gen: divides i_clk by QDIV, o_tick pulses once per SCL quarter period
// Ports: i_clk/i_rst clock and sync reset; i_clr restarts the count at 0; o_tick one-cycle pulse
module i2c_qtick_gen #(
  parameter int QDIV = 4,
  parameter int CW = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    o_tick = cnt_q == CW'(QDIV - 1);
    cnt_d = (i_clr || o_tick) ? '0 : cnt_q + CW'(1);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/i2c_master_prog.sv
// i2c_master_prog: open-drain I2C initiator for single-register writes and reads
// Ports: i_start/i_rw/i_dev_addr/i_reg_addr/i_wdata request (latched at accept);
//        o_rdata/o_busy/o_done/o_nack status; i_sda resolved bus, o_sda_oe/o_scl_oe pull-low enables
module i2c_master_prog
  import i2c_pkg::*;
#(
  parameter int QDIV = 4,
  parameter int CW = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_rw,
  input  logic [6:0] i_dev_addr,
  input  logic [7:0] i_reg_addr,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_rdata,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_nack,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic       o_scl_oe
);
  state_e state_q, state_d;
  logic [1:0] ph_q, ph_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] wd_q, wd_d;
  logic [6:0] dev_q, dev_d;
  logic rw_q, rw_d;
  logic rx_q, rx_d;
  logic err_q, err_d;
  logic nack_q, nack_d;
  logic tick, accept, active, seg_end, is_bit;
  assign accept = state_q == IDLE && i_start;
  assign active = state_q != IDLE && state_q != DONE;
  assign seg_end = tick && ph_q == P3;
  assign is_bit = is_tx(state_q) || state_q == RDATA;
  i2c_qtick_gen #(.QDIV(QDIV), .CW(CW)) u_qtick (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (accept),
    .o_tick(tick)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = i_start ? START : IDLE;
      START:   if (seg_end) state_d = ADDR;
      ADDR:    if (seg_end && bit_q == 3'd7) state_d = ACK1;
      ACK1:    if (seg_end) state_d = err_q ? STOP : REG;
      REG:     if (seg_end && bit_q == 3'd7) state_d = ACK2;
      ACK2:    if (seg_end) state_d = err_q ? STOP : (rw_q == RW_READ ? RSTART : WDATA);
      WDATA:   if (seg_end && bit_q == 3'd7) state_d = ACK3;
      ACK3:    if (seg_end) state_d = STOP;
      RSTART:  if (seg_end) state_d = RADDR;
      RADDR:   if (seg_end && bit_q == 3'd7) state_d = ACK4;
      ACK4:    if (seg_end) state_d = err_q ? STOP : RDATA;
      RDATA:   if (seg_end && bit_q == 3'd7) state_d = MNACK;
      MNACK:   if (seg_end) state_d = STOP;
      STOP:    if (seg_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // The bus bit is captured mid-high (p2) and shifted in at segment end, so the
  // transmitted MSB stays stable until SCL is low again.
  always_comb begin
    ph_d = accept ? P0 : (active && tick) ? ph_q + 2'd1 : ph_q;
    bit_d = accept ? 3'd0 : (is_bit && seg_end) ? bit_q + 3'd1 : bit_q;
    rx_d = (tick && ph_q == P2) ? i_sda : rx_q;
    err_d = accept ? 1'b0 : (is_ack(state_q) && tick && ph_q == P2 && i_sda) ? 1'b1 : err_q;
    nack_d = accept ? 1'b0 : (state_q == STOP && seg_end) ? err_q : nack_q;
    rdata_d = (state_q == STOP && seg_end && rw_q != RW_WRITE) ? sr_q : rdata_q;
    rw_d = accept ? i_rw : rw_q;
    dev_d = accept ? i_dev_addr : dev_q;
    reg_d = accept ? i_reg_addr : reg_q;
    wd_d = accept ? i_wdata : wd_q;
    sr_d = !seg_end ? sr_q :
           state_q == START  ? {dev_q, RW_WRITE} :
           state_q == ACK1   ? reg_q :
           state_q == ACK2   ? wd_q :
           state_q == RSTART ? {dev_q, RW_READ} :
           is_bit            ? {sr_q[6:0], rx_q} : sr_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ph_q <= P0;
      bit_q <= '0;
      sr_q <= '0;
      rdata_q <= '0;
      reg_q <= '0;
      wd_q <= '0;
      dev_q <= '0;
      rw_q <= 1'b0;
      rx_q <= 1'b0;
      err_q <= 1'b0;
      nack_q <= 1'b0;
    end else begin
      ph_q <= ph_d;
      bit_q <= bit_d;
      sr_q <= sr_d;
      rdata_q <= rdata_d;
      reg_q <= reg_d;
      wd_q <= wd_d;
      dev_q <= dev_d;
      rw_q <= rw_d;
      rx_q <= rx_d;
      err_q <= err_d;
      nack_q <= nack_d;
    end
  end
  // A repeated START keeps SCL low in p0; a START from idle finds SCL already released.
  always_comb begin
    o_busy = active;
    o_done = state_q == DONE;
    o_nack = nack_q;
    o_rdata = rdata_q;
    o_sda_oe = (state_q == START || state_q == RSTART) ? ph_q inside {P2, P3} :
               is_tx(state_q)  ? ~sr_q[7] :
               state_q == STOP ? ph_q inside {P0, P1} : 1'b0;
    o_scl_oe = (state_q == START || state_q == RSTART) ? (ph_q == P0 ? state_q == RSTART : ph_q == P3) :
               state_q == STOP ? ph_q == P0 :
               active          ? (ph_q == P0 || ph_q == P3) : 1'b0;
  end
endmodule

// File: tb/tb_i2c_master_prog.sv
// tb_i2c_master_prog: directed checks of the I2C programmer against a behavioural slave on each bus
module tb_i2c_master_prog;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] start = '0;
  logic [1:0] ack_en = 2'b11;
  logic rw = 1'b0;
  logic [6:0] dev = '0;
  logic [7:0] regb = '0;
  logic [7:0] wdata = '0;
  logic [7:0] txb = '0;
  logic [1:0] busy_v, done_v;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : ch
    logic [7:0] rdata, sh;
    logic busy, done, nack, sda_oe, scl_oe, scl, sda;
    logic pull = 1'b0;
    logic first, tx, scl_p, sda_p, mack;
    int cnt;
    int blog[$];
    assign scl = ~scl_oe;
    assign sda = ~(sda_oe | pull);
    assign busy_v[g] = busy;
    assign done_v[g] = done;
    i2c_master_prog #(.QDIV(g == 0 ? 2 : 1), .CW(8)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_start   (start[g]),
      .i_rw      (rw),
      .i_dev_addr(dev),
      .i_reg_addr(regb),
      .i_wdata   (wdata),
      .o_rdata   (rdata),
      .o_busy    (busy),
      .o_done    (done),
      .o_nack    (nack),
      .i_sda     (sda),
      .o_sda_oe  (sda_oe),
      .o_scl_oe  (scl_oe)
    );
    // Slave: logs START (256), STOP (257) and every byte it receives; ACKs when
    // enabled and returns txb for a read address.
    always @(posedge clk) begin
      if (rst) begin
        cnt = 0; tx = 1'b0; first = 1'b0; scl_p = 1'b1; sda_p = 1'b1; pull <= 1'b0;
      end else begin
        if (scl && scl_p && sda_p && !sda) begin
          blog.push_back(256); cnt = 0; first = 1'b1; tx = 1'b0;
        end else if (scl && scl_p && !sda_p && sda) begin
          blog.push_back(257); cnt = 0;
        end else if (scl && !scl_p) begin
          if (cnt < 8) sh = {sh[6:0], sda};
          else mack = sda;
          cnt++;
        end else if (!scl && scl_p) begin
          if (cnt == 8 && !tx) begin
            blog.push_back(int'(sh)); pull <= ack_en[g]; tx = first && sh[0]; first = 1'b0;
          end else if (cnt == 8) begin
            pull <= 1'b0; tx = 1'b0;
          end else if (cnt == 9) begin
            cnt = 0; pull <= tx && !txb[7];
          end else if (tx) pull <= !txb[7 - cnt];
        end
        scl_p = scl; sda_p = sda;
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_bus(input string tag, input int act[$], input int exp[$]);
    chk({tag, "_len"}, act.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), i < act.size() ? act[i] : -1, exp[i]);
  endtask
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic wait_done(input int g, input int bound, output int k);
    k = 1;
    while (!done_v[g] && k < bound) begin
      cyc();
      k++;
    end
  endtask
  task automatic launch(input int g);
    start[g] = 1'b1;
    cyc();
    start[g] = 1'b0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int k, gaps, dones;
    int exp_q[$];
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy_v[0], 1'b0);
    chk("rst_done", done_v[0], 1'b0);
    chk("rst_nack", ch[0].nack, 1'b0);
    chk("rst_rdata", ch[0].rdata, 8'h00);
    chk("rst_sda_oe", ch[0].sda_oe, 1'b0);
    chk("rst_scl_oe", ch[0].scl_oe, 1'b0);
    rst = 1'b0;
    cyc();
    // write 0xA5 to reg 0x10 of device 0x2A
    rw = 1'b0; dev = 7'h2A; regb = 8'h10; wdata = 8'hA5;
    ch[0].blog.delete();
    launch(0);
    chk("wr_busy", busy_v[0], 1'b1);
    wait_done(0, 400, k);
    chk("wr_lat", k, 233);
    chk("wr_busy_at_done", busy_v[0], 1'b0);
    chk("wr_nack", ch[0].nack, 1'b0);
    chk("wr_sda_rel", ch[0].sda_oe, 1'b0);
    chk("wr_scl_rel", ch[0].scl_oe, 1'b0);
    exp_q = {256, 'h54, 'h10, 'hA5, 257};
    chk_bus("wr_bus", ch[0].blog, exp_q);
    cyc();
    chk("wr_done_pulse", done_v[0], 1'b0);
    // read reg 0x04, slave answers 0x3C
    rw = 1'b1; regb = 8'h04; txb = 8'h3C;
    ch[0].blog.delete();
    launch(0);
    wait_done(0, 400, k);
    chk("rd_lat", k, 313);
    chk("rd_rdata", ch[0].rdata, 8'h3C);
    chk("rd_nack", ch[0].nack, 1'b0);
    chk("rd_master_nack", ch[0].mack, 1'b1);
    exp_q = {256, 'h54, 'h04, 256, 'h55, 257};
    chk_bus("rd_bus", ch[0].blog, exp_q);
    cyc();
    chk("rd_rdata_held", ch[0].rdata, 8'h3C);
    // no slave responds
    ack_en[0] = 1'b0; rw = 1'b0;
    ch[0].blog.delete();
    launch(0);
    wait_done(0, 400, k);
    chk("nk_lat", k, 89);
    chk("nk_nack", ch[0].nack, 1'b1);
    chk("nk_sda_rel", ch[0].sda_oe, 1'b0);
    chk("nk_scl_rel", ch[0].scl_oe, 1'b0);
    exp_q = {256, 'h54, 257};
    chk_bus("nk_bus", ch[0].blog, exp_q);
    cyc();
    chk("nk_nack_held", ch[0].nack, 1'b1);
    ack_en[0] = 1'b1;
    cyc();
    // i_start held high across a whole transaction
    start[0] = 1'b1;
    cyc();
    k = 1; gaps = 0;
    while (!done_v[0] && k < 400) begin
      cyc();
      k++;
      if (!busy_v[0] && !done_v[0]) gaps++;
    end
    chk("hold_lat", k, 233);
    chk("hold_gaps", gaps, 0);
    chk("hold_nack_cleared", ch[0].nack, 1'b0);
    cyc();
    chk("hold_idle_gap", busy_v[0], 1'b0);
    cyc();
    chk("hold_restart", busy_v[0], 1'b1);
    start[0] = 1'b0;
    wait_done(0, 400, k);
    chk("hold_lat2", k, 233);
    cyc();
    cyc();
    chk("hold_no_third", busy_v[0], 1'b0);
    // reset in the middle of the register byte
    rw = 1'b0;
    launch(0);
    repeat (84) cyc();
    chk("mid_busy", busy_v[0], 1'b1);
    rst = 1'b1;
    cyc();
    chk("mid_sda_rel", ch[0].sda_oe, 1'b0);
    chk("mid_scl_rel", ch[0].scl_oe, 1'b0);
    chk("mid_busy_rst", busy_v[0], 1'b0);
    chk("mid_done_rst", done_v[0], 1'b0);
    rst = 1'b0;
    dones = 0;
    repeat (300) begin
      cyc();
      if (done_v[0]) dones++;
    end
    chk("mid_no_done", dones, 0);
    // fastest divider
    rw = 1'b0; dev = 7'h2A; regb = 8'h10; wdata = 8'hA5;
    ch[1].blog.delete();
    launch(1);
    wait_done(1, 400, k);
    chk("q1_lat", k, 117);
    chk("q1_nack", ch[1].nack, 1'b0);
    chk("q1_sda_rel", ch[1].sda_oe, 1'b0);
    chk("q1_scl_rel", ch[1].scl_oe, 1'b0);
    exp_q = {256, 'h54, 'h10, 'hA5, 257};
    chk_bus("q1_bus", ch[1].blog, exp_q);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
